// File: rtl/pipeline_stall_sequencer_if.sv
// Hazard-request and pipeline-control bundle of the stall sequencer.
// The slave side is the sequencer, the master side is the pipeline.
interface pipeline_stall_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             lu_hazard;
    logic             br_ld_ex;
    logic             br_ld_mem;
    logic             br_taken;
    logic             mem_busy;
    logic             holdPC;
    logic             holdIF_ID;
    logic             muxSelector;
    logic             holdID_EX;
    logic             holdEX_MEM;
    logic             flushIF_ID;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;

    modport master (
        output lu_hazard, br_ld_ex, br_ld_mem, br_taken, mem_busy,
        input  holdPC, holdIF_ID, muxSelector, holdID_EX, holdEX_MEM,
        input  flushIF_ID, stall_cycles, mem_timeout
    );

    modport slave (
        input  lu_hazard, br_ld_ex, br_ld_mem, br_taken, mem_busy,
        output holdPC, holdIF_ID, muxSelector, holdID_EX, holdEX_MEM,
        output flushIF_ID, stall_cycles, mem_timeout
    );
endinterface

// File: rtl/pipeline_stall_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Mealy control outputs, stall counter and sticky memory-timeout flag.
module pipeline_stall_sequencer #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    pipeline_stall_sequencer_if.slave bus
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    state_t           resume, resume_nxt;
    state_t           eff;
    logic [WC_W-1:0]  wait_cnt, wait_nxt;
    logic [CNT_W-1:0] cnt;
    logic             timeout;

    logic hold_pc, hold_ifid, mux_sel, hold_idex, hold_exmem, flush_ifid;

    // Next-state and Mealy control decode; the wait state replays the
    // interrupted state once memory is ready.
    always_comb begin
        state_nxt  = state;
        resume_nxt = resume;
        wait_nxt   = wait_cnt;
        hold_pc    = 1'b0;
        hold_ifid  = 1'b0;
        mux_sel    = 1'b0;
        hold_idex  = 1'b0;
        hold_exmem = 1'b0;
        flush_ifid = 1'b0;
        eff        = (state == MEM_WAIT) ? resume : state;
        if (!rst_n) begin
            state_nxt = RUN;
        end else if (state == MEM_WAIT && bus.mem_busy) begin
            hold_pc    = 1'b1;
            hold_ifid  = 1'b1;
            hold_idex  = 1'b1;
            hold_exmem = 1'b1;
            if (wait_cnt != WC_MAX)
                wait_nxt = wait_cnt + WC_W'(1);
        end else begin
            if (state == MEM_WAIT)
                wait_nxt = '0;
            unique case (eff)
                RUN: begin
                    state_nxt = RUN;
                    if (bus.mem_busy) begin
                        hold_pc    = 1'b1;
                        hold_ifid  = 1'b1;
                        hold_idex  = 1'b1;
                        hold_exmem = 1'b1;
                        resume_nxt = RUN;
                        wait_nxt   = WC_W'(1);
                        state_nxt  = MEM_WAIT;
                    end else if (bus.br_ld_ex) begin
                        hold_pc   = 1'b1;
                        hold_ifid = 1'b1;
                        mux_sel   = 1'b1;
                        state_nxt = BR_STALL;
                    end else if (bus.lu_hazard || bus.br_ld_mem) begin
                        hold_pc   = 1'b1;
                        hold_ifid = 1'b1;
                        mux_sel   = 1'b1;
                    end else if (bus.br_taken) begin
                        flush_ifid = 1'b1;
                    end
                end
                BR_STALL: begin
                    if (bus.mem_busy) begin
                        hold_pc    = 1'b1;
                        hold_ifid  = 1'b1;
                        hold_idex  = 1'b1;
                        hold_exmem = 1'b1;
                        resume_nxt = BR_STALL;
                        wait_nxt   = WC_W'(1);
                        state_nxt  = MEM_WAIT;
                    end else begin
                        hold_pc   = 1'b1;
                        hold_ifid = 1'b1;
                        mux_sel   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // State, resume target, wait counter, stall counter and timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            resume   <= RUN;
            wait_cnt <= '0;
            cnt      <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            resume   <= resume_nxt;
            wait_cnt <= wait_nxt;
            if (hold_pc && cnt != '1)
                cnt <= cnt + CNT_W'(1);
            if (bus.mem_busy && wait_nxt == WC_MAX)
                timeout <= 1'b1;
        end
    end

    assign bus.holdPC       = hold_pc;
    assign bus.holdIF_ID    = hold_ifid;
    assign bus.muxSelector  = mux_sel;
    assign bus.holdID_EX    = hold_idex;
    assign bus.holdEX_MEM   = hold_exmem;
    assign bus.flushIF_ID   = flush_ifid;
    assign bus.stall_cycles = cnt;
    assign bus.mem_timeout  = timeout;
endmodule

// File: doc/pipeline_stall_sequencer.md
Name: pipeline_stall_sequencer

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Takes resolved hazard conditions from the ID-stage hazard logic, branch resolution and data-memory handshake.
- Sequences single- and multi-cycle stalls, ID/EX bubble insertion, IF/ID flush and whole-pipeline freeze.
- Keeps a stall performance counter and a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 64, consecutive mem_busy cycles after which mem_timeout is set
CNT_W, 16, width of stall_cycles counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
lu_hazard  input  1  load in ID/EX writes a register read by the instruction in IF/ID
br_ld_ex  input  1  branch in IF/ID depends on a load currently in ID/EX; needs 2 stalls
br_ld_mem  input  1  branch in IF/ID depends on a load currently in EX/MEM; needs 1 stall
br_taken  input  1  branch/jump resolved taken in ID
mem_busy  input  1  data memory not ready; whole pipeline must freeze
holdPC  output  1  PC keeps its value
holdIF_ID  output  1  IF/ID register keeps its value
muxSelector  output  1  zero control bits into ID/EX (bubble)
holdID_EX  output  1  ID/EX register keeps its value
holdEX_MEM  output  1  EX/MEM register keeps its value
flushIF_ID  output  1  IF/ID loaded with NOP
stall_cycles  output  CNT_W  saturating count of cycles with holdPC=1
mem_timeout  output  1  sticky memory-timeout error

Behaviour:
- State register: RUN, BR_STALL, MEM_WAIT. Additional registers: resume (RUN/BR_STALL), wait_cnt, stall_cycles, mem_timeout.
- Control outputs are Mealy (state + current inputs, same cycle). All control outputs are forced to 0 while rst_n=0.
- Reset, on a clk edge with rst_n=0: state=RUN, resume=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0.
- Output sets:
  - FREEZE: holdPC=holdIF_ID=holdID_EX=holdEX_MEM=1, muxSelector=0, flushIF_ID=0.
  - STALL: holdPC=holdIF_ID=muxSelector=1, all others 0.
  - FLUSH: flushIF_ID=1, all others 0.
  - IDLE: all 0.
- RUN, priority high to low:
  - mem_busy: FREEZE; resume=RUN; wait_cnt=1; next MEM_WAIT.
  - br_ld_ex: STALL; next BR_STALL (2 stall cycles total).
  - lu_hazard or br_ld_mem: STALL; stay RUN. The upstream condition clears after one cycle; if it persists, stalling repeats.
  - br_taken: FLUSH; stay RUN.
  - otherwise: IDLE.
- BR_STALL:
  - mem_busy: FREEZE; resume=BR_STALL; wait_cnt=1; next MEM_WAIT.
  - else: STALL; next RUN.
  - lu_hazard, br_ld_*, br_taken are ignored in this state.
- MEM_WAIT:
  - mem_busy=1: FREEZE; wait_cnt increments, saturating at MEM_TIMEOUT. When wait_cnt==MEM_TIMEOUT, set mem_timeout=1. It stays set until reset; the state stays MEM_WAIT.
  - mem_busy=0: outputs and next state are computed exactly as in state 'resume' with mem_busy treated as 0. wait_cnt clears to 0.
- A stall with a simultaneous br_taken: the stall wins; no flush in that cycle.
- stall_cycles increments on every non-reset cycle where holdPC=1 (stall or freeze). It saturates at 2^CNT_W-1 with no wrap.
- Reset asserted mid-stall or mid-wait aborts the sequence; the pending BR_STALL is discarded.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all inputs=1 -> all control outputs 0, stall_cycles=0, mem_timeout=0; after release and inputs=0 -> IDLE in RUN.
- lu_hazard pulse 1 cycle -> holdPC=holdIF_ID=muxSelector=1 for exactly 1 cycle; stall_cycles=1.
- br_ld_ex pulse 1 cycle, with br_taken=1 in both stall cycles -> 2 STALL cycles with flushIF_ID=0; next cycle br_taken=1 -> flushIF_ID=1 alone; stall_cycles=2.
- br_ld_ex, then mem_busy=1 for 3 cycles during the second stall cycle -> 1 STALL, 3 FREEZE (muxSelector=0), then the pending STALL on the mem_busy=0 cycle; stall_cycles=5.
- MEM_TIMEOUT=4, mem_busy held 6 cycles -> mem_timeout rises at the 4th busy cycle and stays 1 after mem_busy drops; it clears only on rst_n=0.
- CNT_W=3, lu_hazard held 10 cycles -> stall_cycles reaches 7 and holds at 7.
